// File: rtl/pemstat_bank.sv
// Bank of NCH independent event counters with sticky overflow flags and a
// single-port host interface (write, read, optional clear-on-read).
module pemstat_bank #(
  parameter int NCH  = 4,
  parameter int CW   = 12,
  parameter int INCW = 1,
  parameter int AW   = 5,
  parameter int SAT  = 0,
  parameter int COR  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCH-1:0]      inc_vld,
  input  logic [NCH*INCW-1:0] inc_amt,
  input  logic                clr_all,
  input  logic                host_sel,
  input  logic                host_wr,
  input  logic [AW-1:0]       host_addr,
  input  logic [30:0]         host_wdata,
  output logic [30:0]         host_rdata,
  output logic                host_rvld,
  output logic [NCH-1:0]      ovf,
  input  logic [NCH-1:0]      ovf_clr
);

  logic          rd_req;
  logic          wr_req;
  logic [NCH*CW-1:0] cnt_flat;
  logic [CW-1:0] rd_val;
  logic          unused_wdata;

  assign rd_req       = host_sel & ~host_wr;
  assign wr_req       = host_sel & host_wr;
  assign unused_wdata = ^host_wdata;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [INCW-1:0] amt;
    logic [CW:0]     sum;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_nxt;
    logic            ovf_q;
    logic            ovf_nxt;
    logic            carry;
    logic            addr_hit;

    assign amt      = inc_amt[i*INCW +: INCW];
    assign addr_hit = (host_addr == AW'(i));
    assign sum      = {1'b0, cnt_q} + (CW+1)'(amt);

    // Rules are evaluated in strict priority; only the increment path can carry.
    always_comb begin
      cnt_nxt = cnt_q;
      carry   = 1'b0;
      if (clr_all) begin
        cnt_nxt = '0;
      end else if (wr_req && addr_hit) begin
        cnt_nxt = host_wdata[CW-1:0];
      end else if ((COR != 0) && rd_req && addr_hit && inc_vld[i]) begin
        cnt_nxt = CW'(amt);
      end else if ((COR != 0) && rd_req && addr_hit) begin
        cnt_nxt = '0;
      end else if (inc_vld[i]) begin
        carry = sum[CW];
        if (sum[CW] && (SAT != 0)) begin
          cnt_nxt = '1;
        end else begin
          cnt_nxt = sum[CW-1:0];
        end
      end
    end

    always_comb begin
      ovf_nxt = ovf_q;
      if (clr_all || ovf_clr[i]) begin
        ovf_nxt = 1'b0;
      end else if (carry) begin
        ovf_nxt = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_nxt;
        ovf_q <= ovf_nxt;
      end
    end

    assign cnt_flat[i*CW +: CW] = cnt_q;
    assign ovf[i]               = ovf_q;
  end

  // Addresses with no matching channel fall through to zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NCH; i++) begin
      if (host_addr == AW'(i)) begin
        rd_val = cnt_flat[i*CW +: CW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_rdata <= '0;
      host_rvld  <= 1'b0;
    end else begin
      host_rvld <= rd_req;
      if (rd_req) begin
        host_rdata <= 31'(rd_val);
      end
    end
  end

endmodule

// File: tb/tb_pemstat_bank.sv
// Self-checking bench: two pemstat_bank instances (wrap/clear-on-read and
// saturate/non-destructive) share stimulus and are checked against a model.
module tb_pemstat_bank;

  localparam int NCH  = 4;
  localparam int CW   = 8;
  localparam int INCW = 4;
  localparam int AW   = 3;

  logic                clk;
  logic                rst_n;
  logic [NCH-1:0]      inc_vld;
  logic [NCH*INCW-1:0] inc_amt;
  logic                clr_all;
  logic                host_sel;
  logic                host_wr;
  logic [AW-1:0]       host_addr;
  logic [30:0]         host_wdata;
  logic [NCH-1:0]      ovf_clr;

  logic [30:0]    d_rdata [2];
  logic           d_rvld  [2];
  logic [NCH-1:0] d_ovf   [2];

  int  vectors;
  int  miscompares;
  bit  cmp_en;

  typedef struct packed {
    logic [3:0][7:0] cnt;
    logic [3:0]      ovf;
    logic [30:0]     rdata;
    logic            rvld;
  } mstate_t;

  mstate_t m [2];

  pemstat_bank #(.NCH(NCH), .CW(CW), .INCW(INCW), .AW(AW), .SAT(0), .COR(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .inc_vld(inc_vld), .inc_amt(inc_amt),
    .clr_all(clr_all), .host_sel(host_sel), .host_wr(host_wr),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(d_rdata[0]),
    .host_rvld(d_rvld[0]), .ovf(d_ovf[0]), .ovf_clr(ovf_clr)
  );

  pemstat_bank #(.NCH(NCH), .CW(CW), .INCW(INCW), .AW(AW), .SAT(1), .COR(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .inc_vld(inc_vld), .inc_amt(inc_amt),
    .clr_all(clr_all), .host_sel(host_sel), .host_wr(host_wr),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(d_rdata[1]),
    .host_rvld(d_rvld[1]), .ovf(d_ovf[1]), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Next-state of one bank from the current inputs, using plain integer arithmetic.
  function automatic mstate_t model_step(mstate_t s, bit sat, bit cor);
    mstate_t n;
    int  a;
    bit  rd;
    bit  wr;
    n  = s;
    a  = int'(host_addr);
    rd = host_sel && !host_wr;
    wr = host_sel && host_wr;
    n.rvld = rd;
    if (rd) n.rdata = (a < NCH) ? 31'(s.cnt[a]) : 31'd0;
    for (int i = 0; i < NCH; i++) begin
      int amt;
      int c;
      bit carry;
      amt   = int'(inc_amt[4*i +: 4]);
      c     = int'(s.cnt[i]);
      carry = 1'b0;
      if (clr_all) c = 0;
      else if (wr && a == i) c = int'(host_wdata) % 256;
      else if (cor && rd && a == i) c = inc_vld[i] ? amt : 0;
      else if (inc_vld[i]) begin
        c = c + amt;
        if (c > 255) begin
          carry = 1'b1;
          c = sat ? 255 : c - 256;
        end
      end
      n.cnt[i] = 8'(c);
      if (clr_all || ovf_clr[i]) n.ovf[i] = 1'b0;
      else if (carry) n.ovf[i] = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= '0;
      m[1] <= '0;
    end else begin
      m[0] <= model_step(m[0], 1'b0, 1'b1);
      m[1] <= model_step(m[1], 1'b1, 1'b0);
    end
  end

  task automatic check_output(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every falling edge: all outputs of both banks against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        check_output($sformatf("bank%0d.rvld", k), int'(d_rvld[k]), int'(m[k].rvld));
        check_output($sformatf("bank%0d.rdata", k), int'(d_rdata[k]), int'(m[k].rdata));
        check_output($sformatf("bank%0d.ovf", k), int'(d_ovf[k]), int'(m[k].ovf));
      end
    end
  end

  task automatic apply_stimulus(input logic [3:0] vld, input logic [15:0] amt,
                                input logic clr, input logic sel, input logic wr,
                                input logic [2:0] addr, input logic [30:0] wdata,
                                input logic [3:0] oclr);
    inc_vld    = vld;
    inc_amt    = amt;
    clr_all    = clr;
    host_sel   = sel;
    host_wr    = wr;
    host_addr  = addr;
    host_wdata = wdata;
    ovf_clr    = oclr;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [2:0] addr, input logic [30:0] data);
    apply_stimulus(4'h0, 16'h0, 1'b0, 1'b1, 1'b1, addr, data, 4'h0);
  endtask

  task automatic do_read(input logic [2:0] addr);
    apply_stimulus(4'h0, 16'h0, 1'b0, 1'b1, 1'b0, addr, 31'd0, 4'h0);
  endtask

  task automatic check_read(input string name, input int exp_a, input int exp_b);
    check_output({name, ".a.rvld"}, int'(d_rvld[0]), 1);
    check_output({name, ".a.rdata"}, int'(d_rdata[0]), exp_a);
    check_output({name, ".b.rvld"}, int'(d_rvld[1]), 1);
    check_output({name, ".b.rdata"}, int'(d_rdata[1]), exp_b);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cmp_en      = 1'b0;
    rst_n       = 1'b1;
    inc_vld     = '0;
    inc_amt     = '0;
    clr_all     = 1'b0;
    host_sel    = 1'b0;
    host_wr     = 1'b0;
    host_addr   = '0;
    host_wdata  = '0;
    ovf_clr     = '0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    // Accumulate 3 x 5 on channel 1, then two reads.
    for (int n = 0; n < 3; n++)
      apply_stimulus(4'b0010, 16'h0050, 1'b0, 1'b0, 1'b0, 3'd0, 31'd0, 4'h0);
    do_read(3'd1);
    check_read("cor_first", 15, 15);
    do_read(3'd1);
    check_read("cor_second", 0, 15);

    // 0xFE + 3: wrap to 0x01 vs saturate at 0xFF, both flag overflow.
    do_write(3'd2, 31'h0FE);
    apply_stimulus(4'b0100, 16'h0300, 1'b0, 1'b0, 1'b0, 3'd0, 31'd0, 4'h0);
    check_output("wrap.a.ovf2", int'(d_ovf[0][2]), 1);
    check_output("sat.b.ovf2", int'(d_ovf[1][2]), 1);
    do_read(3'd2);
    check_read("wrap_sat", 1, 255);

    // Asynchronous reset pulse between edges clears everything immediately.
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_output($sformatf("areset.bank%0d.rvld", k), int'(d_rvld[k]), 0);
      check_output($sformatf("areset.bank%0d.rdata", k), int'(d_rdata[k]), 0);
      check_output($sformatf("areset.bank%0d.ovf", k), int'(d_ovf[k]), 0);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Read concurrent with an increment.
    do_write(3'd0, 31'd20);
    apply_stimulus(4'b0001, 16'h0007, 1'b0, 1'b1, 1'b0, 3'd0, 31'd0, 4'h0);
    check_read("rd_inc_first", 20, 20);
    do_read(3'd0);
    check_read("rd_inc_second", 7, 27);

    // Carry and overflow clear in the same cycle: the clear wins.
    do_write(3'd3, 31'h0FF);
    apply_stimulus(4'b1000, 16'h1000, 1'b0, 1'b0, 1'b0, 3'd0, 31'd0, 4'b1000);
    check_output("ovfclr.a.ovf3", int'(d_ovf[0][3]), 0);
    check_output("ovfclr.b.ovf3", int'(d_ovf[1][3]), 0);
    do_read(3'd3);
    check_read("ovfclr_cnt", 0, 255);
    do_read(3'd5);
    check_read("oob_read", 0, 0);

    // Reset asserted before the edge that would return a read.
    inc_vld   = '0;
    host_sel  = 1'b1;
    host_wr   = 1'b0;
    host_addr = 3'd0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_output("rst_rd.a.rvld", int'(d_rvld[0]), 0);
    check_output("rst_rd.a.rdata", int'(d_rdata[0]), 0);
    check_output("rst_rd.b.rvld", int'(d_rvld[1]), 0);
    check_output("rst_rd.b.rdata", int'(d_rdata[1]), 0);
    host_sel = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_output("rst_rd.after.a.rvld", int'(d_rvld[0]), 0);

    // Randomized traffic checked cycle by cycle against the model.
    for (int n = 0; n < 2000; n++) begin
      logic [3:0] oclr;
      for (int b = 0; b < 4; b++) oclr[b] = ($urandom_range(0, 15) == 0);
      apply_stimulus(4'($urandom), 16'($urandom), ($urandom_range(0, 63) == 0),
                     ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                     3'($urandom_range(0, 7)), 31'($urandom), oclr);
    end

    apply_stimulus(4'h0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 31'd0, 4'h0);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pemstat_bank.md
PEMSTAT_BANK -- requirements
Module: pemstat_bank

Interface
REQ-001 Parameter NCH, default 4: number of counter channels, range 1..32.
REQ-002 Parameter CW, default 12: counter width in bits, range 2..31.
REQ-003 Parameter INCW, default 1: increment-amount width in bits, range 1..CW.
REQ-004 Parameter AW, default 5: host address width, with 2^AW >= NCH.
REQ-005 Parameter SAT, default 0: 0 = wrap on carry, 1 = saturate at all-ones.
REQ-006 Parameter COR, default 1: 1 = clear-on-read, 0 = reads are non-destructive.
REQ-007 clk  in  1: sole clock, rising edge.
REQ-008 rst_n  in  1: reset, asynchronous and active-low.
REQ-009 inc_vld  in  NCH: per-channel increment strobe.
REQ-010 inc_amt  in  NCH*INCW: per-channel increment amount; channel i occupies bits [i*INCW +: INCW].
REQ-011 clr_all  in  1: synchronous clear of all counters and all overflow flags.
REQ-012 host_sel  in  1: host access strobe, one access per cycle.
REQ-013 host_wr  in  1: 1 = write, 0 = read; qualified by host_sel.
REQ-014 host_addr  in  AW: channel index.
REQ-015 host_wdata  in  31: write data; bits [CW-1:0] are used.
REQ-016 host_rdata  out  31: read data, counter value zero-extended to 31 bits.
REQ-017 host_rvld  out  1: one-cycle pulse marking valid host_rdata.
REQ-018 ovf  out  NCH: per-channel sticky overflow flag.
REQ-019 ovf_clr  in  NCH: per-channel synchronous overflow-flag clear.

Function
REQ-020 Each channel i SHALL hold a CW-bit counter cnt[i], updated once per clk edge by the first matching rule below.
REQ-021 Rule 1, clr_all=1: cnt[i] <= 0.
REQ-022 Rule 2, host write to address i: cnt[i] <= host_wdata[CW-1:0]; a same-cycle increment is dropped.
REQ-023 Rule 3, host read of address i with COR=1 and inc_vld[i]=1: cnt[i] <= inc_amt[i], zero-extended.
REQ-024 Rule 4, host read of address i with COR=1: cnt[i] <= 0.
REQ-025 Rule 5, inc_vld[i]=1: form sum = cnt[i] + inc_amt[i] at CW+1 bits.
REQ-026 Rule 5 result on carry (sum[CW]=1): SAT=0 gives cnt[i] <= sum[CW-1:0]; SAT=1 gives cnt[i] <= all-ones.
REQ-027 Rule 5 result without carry: cnt[i] <= sum[CW-1:0].
REQ-028 Rule 6, otherwise: cnt[i] holds.
REQ-029 With SAT=1, a counter at all-ones plus any increment SHALL stay all-ones and SHALL set ovf[i].
REQ-030 On a read (host_sel=1, host_wr=0), host_rdata SHALL present the pre-update cnt[addr], zero-extended, on the next cycle with host_rvld=1 for exactly that cycle.
REQ-031 Read-to-data latency SHALL be 1 clk; back-to-back reads SHALL each return data 1 clk later.
REQ-032 host_rdata SHALL hold its last value while host_rvld=0.
REQ-033 An address >= NCH SHALL read as 0 with host_rvld still pulsed; a write to it SHALL have no effect.
REQ-034 Writes SHALL NOT pulse host_rvld.
REQ-035 ovf[i] update, in priority order: clr_all or ovf_clr[i] gives 0; a Rule-5 carry gives 1; otherwise hold.
REQ-036 Host writes and clear-on-read SHALL NOT change ovf[i].
REQ-037 Channels SHALL be fully independent; simultaneous increments on all channels SHALL all be applied in the same cycle.

Reset
REQ-038 While rst_n=0, asynchronously: all cnt[i]=0, ovf=0, host_rdata=0, host_rvld=0.
REQ-039 Assertion of rst_n mid-operation SHALL abort any pending read pulse.
REQ-040 The first update after rst_n deasserts SHALL occur on the first rising clk edge with rst_n=1.

Verification (NCH=4, CW=8, INCW=4, COR=1 unless noted)
REQ-041 Reset: pulse rst_n low between edges -> cnt, ovf, host_rdata and host_rvld all 0 immediately, before the next clk edge.
REQ-042 Clear-on-read: inc_vld[1] with amt 5 for 3 cycles, then read addr 1 -> rdata 15 with rvld 1 cycle later; second read -> rdata 0.
REQ-043 Wrap vs saturate: write ch2=0xFE, then inc 3 -> SAT=0 gives cnt 0x01, ovf[2]=1; SAT=1 gives cnt 0xFF, ovf[2]=1.
REQ-044 Read with increment: ch0=20, read addr 0 while inc_vld[0] with amt 7 -> rdata 20, then next read -> 7; with COR=0 -> 20, then 27.
REQ-045 Simultaneous events: ch3=0xFF, inc 1 with ovf_clr[3]=1 same cycle -> cnt 0x00, ovf[3]=0; out-of-range read addr 5 -> rdata 0, rvld 1.
REQ-046 Reset mid-read: assert rst_n in the cycle after a read -> rvld never seen high, rdata 0.
